// File: rtl/fifo_word_unpacker_if.sv
// fifo_word_unpacker_if: FIFO read port plus byte stream between the unpacker and its neighbours
interface fifo_word_unpacker_if;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_rd;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  modport master (
    input  fifo_empty, fifo_data, byte_ready,
    output fifo_rd, byte_out, byte_valid, byte_last
  );
  modport slave (
    output fifo_empty, fifo_data, byte_ready,
    input  fifo_rd, byte_out, byte_valid, byte_last
  );
endinterface

// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: pops 32-bit FIFO words and emits them as four bytes on a valid/ready stream
module fifo_word_unpacker #(
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 en,
  fifo_word_unpacker_if.master bus,
  output logic [CNT_W-1:0]     word_count,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, REQ, CAP, SEND} state_t;
  state_t           state_q, state_d;
  logic [31:0]      hold_q, hold_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel;
  logic             fetch;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fetch   = en && !bus.fifo_empty;
    if (state_q == IDLE && fetch) state_d = REQ;
    if (state_q == REQ) state_d = CAP;
    // fifo_data is registered inside the FIFO, so it is valid the cycle after RD
    if (state_q == CAP) begin
      hold_d  = bus.fifo_data;
      idx_d   = '0;
      state_d = SEND;
    end
    if (state_q == SEND && bus.byte_ready) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = fetch ? REQ : IDLE;
      end
    end
  end
  assign sel            = LSB_FIRST ? idx_q : ~idx_q;
  assign bus.fifo_rd    = state_q == REQ;
  assign bus.byte_valid = state_q == SEND;
  assign bus.byte_last  = state_q == SEND && idx_q == 2'd3;
  assign bus.byte_out   = state_q == SEND ? hold_q[{sel, 3'b000} +: 8] : 8'h00;
  assign word_count     = cnt_q;
  assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_fifo_word_unpacker.sv
// tb_fifo_word_unpacker: LSB-first/16-bit-count and MSB-first/2-bit-count instances against FIFO models and byte scoreboards
module tb_fifo_word_unpacker;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic busy_a, busy_b;
  int n_cmp = 0, n_err = 0;
  fifo_word_unpacker_if ia ();
  fifo_word_unpacker_if ib ();
  fifo_word_unpacker #(.LSB_FIRST(1'b1), .CNT_W(16)) dut_a (
    .Clk(Clk), .Rst(Rst), .en(en_a), .bus(ia.master), .word_count(cnt_a), .busy(busy_a));
  fifo_word_unpacker #(.LSB_FIRST(1'b0), .CNT_W(2)) dut_b (
    .Clk(Clk), .Rst(Rst), .en(en_b), .bus(ib.master), .word_count(cnt_b), .busy(busy_b));
  always #5 Clk = ~Clk;
  logic [31:0] mem_a [64], mem_b [64];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  logic [8:0] sb_a [$], sb_b [$];
  int rd_t_b [$], last_t_b [$];
  int rdc_a = 0, rdc_b = 0, cyc = 0;
  logic pe_a = 1'b1, pe_b = 1'b1;
  assign ia.fifo_empty = (wr_a == rd_a);
  assign ib.fifo_empty = (wr_b == rd_b);
  initial begin
    ia.fifo_data = '0;
    ib.fifo_data = '0;
  end
  always @(posedge Clk) begin
    if (ia.fifo_rd && wr_a != rd_a) begin
      ia.fifo_data <= mem_a[rd_a % 64];
      rd_a <= rd_a + 1;
    end
    if (ib.fifo_rd && wr_b != rd_b) begin
      ib.fifo_data <= mem_b[rd_b % 64];
      rd_b <= rd_b + 1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push_a(input logic [31:0] w);
    mem_a[wr_a % 64] = w;
    for (int i = 0; i < 4; i++) sb_a.push_back({i == 3, w[8*i +: 8]});
    wr_a++;
  endtask
  task automatic push_b(input logic [31:0] w);
    mem_b[wr_b % 64] = w;
    for (int i = 0; i < 4; i++) sb_b.push_back({i == 3, w[8*(3-i) +: 8]});
    wr_b++;
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic wait_valid_a(input string nm);
    for (int t = 0; t < 10 && !ia.byte_valid; t++) tick();
    chk(nm, ia.byte_valid, 1);
  endtask
  task automatic wait_idle_a(input string nm);
    for (int t = 0; t < 20 && busy_a; t++) tick();
    chk(nm, busy_a, 0);
  endtask
  always @(negedge Clk) begin
    if (!Rst) begin
      if (ia.byte_valid && ia.byte_ready) begin
        n_cmp++;
        if (sb_a.size() == 0) begin
          n_err++;
          $display("FAIL a_extra_byte: got %h expected none", ia.byte_out);
        end else chk("a_byte", {ia.byte_last, ia.byte_out}, sb_a.pop_front());
      end
      if (ib.byte_valid && ib.byte_ready) begin
        if (ib.byte_last) last_t_b.push_back(cyc);
        n_cmp++;
        if (sb_b.size() == 0) begin
          n_err++;
          $display("FAIL b_extra_byte: got %h expected none", ib.byte_out);
        end else chk("b_byte", {ib.byte_last, ib.byte_out}, sb_b.pop_front());
      end
      if (ia.fifo_rd) begin
        rdc_a++;
        chk("a_rd_after_empty", pe_a, 0);
      end
      if (ib.fifo_rd) begin
        rdc_b++;
        rd_t_b.push_back(cyc);
        chk("b_rd_after_empty", pe_b, 0);
      end
    end
    pe_a <= ia.fifo_empty;
    pe_b <= ib.fifo_empty;
    cyc <= cyc + 1;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  typedef struct {
    logic       rdy;
    logic       rd;
    logic       vld;
    logic       last;
    logic       busy;
    logic [7:0] b;
  } vec_t;
  vec_t tv [8];
  int   exp_wrap [5];
  int   rd0;
  initial begin
    tv[0] = '{1, 0, 0, 0, 0, 8'h00};
    tv[1] = '{1, 1, 0, 0, 1, 8'h00};
    tv[2] = '{1, 0, 0, 0, 1, 8'h00};
    tv[3] = '{1, 0, 1, 0, 1, 8'hD4};
    tv[4] = '{1, 0, 1, 0, 1, 8'hC3};
    tv[5] = '{1, 0, 1, 0, 1, 8'hB2};
    tv[6] = '{1, 0, 1, 1, 1, 8'hA1};
    tv[7] = '{1, 0, 0, 0, 0, 8'h00};
    exp_wrap = '{1, 2, 3, 0, 1};
    ia.byte_ready = 1'b0;
    ib.byte_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_a_outs", {ia.fifo_rd, ia.byte_valid, ia.byte_last, busy_a, ia.byte_out}, 0);
    chk("rst_a_cnt", cnt_a, 0);
    chk("rst_b_outs", {ib.fifo_rd, ib.byte_valid, ib.byte_last, busy_b, ib.byte_out, cnt_b}, 0);
    Rst  = 1'b0;
    en_a = 1'b1;
    repeat (20) tick();
    chk("idle_no_rd", rdc_a, 0);
    chk("idle_busy", busy_a, 0);
    push_a(32'hA1B2C3D4);
    for (int i = 0; i < 8; i++) begin
      ia.byte_ready = tv[i].rdy;
      @(negedge Clk);
      chk($sformatf("single_cyc%0d", i),
          {ia.fifo_rd, ia.byte_valid, ia.byte_last, busy_a, ia.byte_out},
          {tv[i].rd, tv[i].vld, tv[i].last, tv[i].busy, tv[i].b});
      tick();
    end
    chk("single_rd_pulses", rdc_a, 1);
    chk("single_count", cnt_a, 1);
    ia.byte_ready = 1'b0;
    push_a(32'h0A0B0C0D);
    wait_valid_a("bp_wait_valid");
    ia.byte_ready = 1'b1;
    tick();
    ia.byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk($sformatf("bp_hold%0d", i), {ia.byte_valid, ia.byte_last, ia.byte_out}, {2'b10, 8'h0C});
      tick();
    end
    ia.byte_ready = 1'b1;
    wait_idle_a("bp_idle");
    chk("bp_sb_drained", sb_a.size(), 0);
    chk("bp_count", cnt_a, 2);
    rd0 = rdc_a;
    push_a(32'h01020304);
    push_a(32'h05060708);
    wait_valid_a("en_wait_valid");
    en_a = 1'b0;
    repeat (12) tick();
    chk("en_drop_one_rd", rdc_a - rd0, 1);
    chk("en_drop_count", cnt_a, 3);
    chk("en_drop_idle", busy_a, 0);
    ia.byte_ready = 1'b0;
    en_a = 1'b1;
    wait_valid_a("rst_wait_valid");
    ia.byte_ready = 1'b1;
    repeat (3) tick();
    ia.byte_ready = 1'b0;
    chk("mid_rst_idx3", {ia.byte_valid, ia.byte_last, ia.byte_out}, {2'b11, 8'h05});
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("mid_rst_left", sb_a.size(), 1);
    sb_a.delete();
    @(negedge Clk);
    chk("mid_rst_outs", {ia.byte_valid, busy_a, cnt_a}, 0);
    tick();
    en_b = 1'b1;
    ib.byte_ready = 1'b1;
    rd_t_b.delete();
    last_t_b.delete();
    push_b(32'h11223344);
    push_b(32'h55667788);
    for (int t = 0; t < 40 && (busy_b || sb_b.size() != 0); t++) tick();
    chk("b2b_sb_drained", sb_b.size(), 0);
    chk("b2b_rd_pulses", rd_t_b.size(), 2);
    chk("b2b_count", cnt_b, 2);
    if (rd_t_b.size() == 2 && last_t_b.size() > 0)
      chk("b2b_rd_timing", rd_t_b[1], last_t_b[0] + 1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    for (int k = 0; k < 5; k++) push_b(32'hC0DE0000 | k);
    for (int k = 0; k < 5; k++) begin
      int t;
      for (t = 0; t < 20; t++) begin
        @(negedge Clk);
        if (ib.byte_valid && ib.byte_ready && ib.byte_last) break;
      end
      chk($sformatf("wrap_wait%0d", k), t < 20, 1);
      @(negedge Clk);
      chk($sformatf("wrap_count%0d", k), cnt_b, exp_wrap[k]);
    end
    tick();
    for (int t = 0; t < 20 && busy_b; t++) tick();
    chk("wrap_sb_drained", sb_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
